rfu_mp: RTL and testbench

//  Parametrised multi-port integer register file for the CPU core; successor to the single-write/dual-read GPR array.

---
 rtl/rfu_pkg.sv | 19 +
 rtl/rfu_mp_if.sv | 42 ++++
 rtl/rfu_wr_arb.sv | 40 ++++
 rtl/rfu_mp.sv | 103 ++++++++++
 tb/tb_rfu_mp.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/rfu_pkg.sv
// rfu_pkg: shared types and default sizes for the multi-port register file.
//   RFU_XLEN / RFU_NREG / RFU_AW : default data width, register count, index width
//   dbg_state_e                  : debug access FSM states (IDLE, ACK)
//   rfu_wr_t                     : one write request {en, addr, data} at default widths
package rfu_pkg;

    localparam int RFU_XLEN = 32;
    localparam int RFU_NREG = 32;
    localparam int RFU_AW   = $clog2(RFU_NREG);

    typedef enum logic {IDLE, ACK} dbg_state_e;

    typedef struct packed {
        logic                en;
        logic [RFU_AW-1:0]   addr;
        logic [RFU_XLEN-1:0] data;
    } rfu_wr_t;

endpackage

// File: rtl/rfu_mp_if.sv
// rfu_mp_if: bus bundle between core (master) and register file (slave).
//   read   : rs_addr -> rs_data, rs_busy (combinational)
//   write  : wen, rd_addr, rd_data
//   issue  : issue_en, issue_rd (scoreboard set)
//   debug  : halted, dbg_req/dbg_wr/dbg_addr/dbg_wdata -> dbg_ack, dbg_rdata
interface rfu_mp_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2,
    parameter int NWP  = 1
);
    localparam int AW = $clog2(NREG);

    logic [NRP-1:0][AW-1:0]   rs_addr;
    logic [NRP-1:0][XLEN-1:0] rs_data;
    logic [NRP-1:0]           rs_busy;
    logic [NWP-1:0]           wen;
    logic [NWP-1:0][AW-1:0]   rd_addr;
    logic [NWP-1:0][XLEN-1:0] rd_data;
    logic                     issue_en;
    logic [AW-1:0]            issue_rd;
    logic                     halted;
    logic                     dbg_req;
    logic                     dbg_wr;
    logic [AW-1:0]            dbg_addr;
    logic [XLEN-1:0]          dbg_wdata;
    logic                     dbg_ack;
    logic [XLEN-1:0]          dbg_rdata;

    modport slave (
        input  rs_addr, wen, rd_addr, rd_data, issue_en, issue_rd,
               halted, dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        output rs_data, rs_busy, dbg_ack, dbg_rdata
    );

    modport master (
        output rs_addr, wen, rd_addr, rd_data, issue_en, issue_rd,
               halted, dbg_req, dbg_wr, dbg_addr, dbg_wdata,
        input  rs_data, rs_busy, dbg_ack, dbg_rdata
    );

endinterface

// File: rtl/rfu_wr_arb.sv
// rfu_wr_arb: folds NWP core write ports plus the debug write into a
// per-register write enable and data. Higher port index overrides lower on
// an address collision; debug has lowest priority (it only fires when no
// core write is active anyway). Register 0 filtering is left to the caller.
//   wen/addr/data       : core write ports
//   dbg_en/dbg_addr/... : debug write request
//   reg_we/reg_wd       : resolved per-register enable and data
module rfu_wr_arb import rfu_pkg::*; #(
    parameter int XLEN = RFU_XLEN,
    parameter int NREG = RFU_NREG,
    parameter int NWP  = 1,
    localparam int AW  = $clog2(NREG)
) (
    input  logic [NWP-1:0]            wen,
    input  logic [NWP-1:0][AW-1:0]    addr,
    input  logic [NWP-1:0][XLEN-1:0]  data,
    input  logic                      dbg_en,
    input  logic [AW-1:0]             dbg_addr,
    input  logic [XLEN-1:0]           dbg_data,
    output logic [NREG-1:0]           reg_we,
    output logic [NREG-1:0][XLEN-1:0] reg_wd
);

    always_comb begin
        reg_we = '0;
        reg_wd = '0;
        if (dbg_en) begin
            reg_we[dbg_addr] = 1'b1;
            reg_wd[dbg_addr] = dbg_data;
        end
        // ascending loop: last matching port (highest index) wins
        for (int j = 0; j < NWP; j++) begin
            if (wen[j]) begin
                reg_we[addr[j]] = 1'b1;
                reg_wd[addr[j]] = data[j];
            end
        end
    end

endmodule

// File: rtl/rfu_mp.sv
// rfu_mp: multi-port integer register file with busy scoreboard and a
// halted-only debug access port.
//   clk, rst : clock; synchronous active-high reset
//   bus      : rfu_mp_if.slave (read ports, write ports, issue, debug)
// Optional feature: define RFU_BYPASS_EN to forward same-cycle write data
// (and a cleared busy bit) onto the read ports.
module rfu_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRP  = 2,
    parameter int NWP  = 1,
    localparam int AW  = $clog2(NREG)
) (
    input  logic     clk,
    input  logic     rst,
    rfu_mp_if.slave  bus
);
    import rfu_pkg::*;

    logic [NREG-1:0][XLEN-1:0] gpr;
    logic [NREG-1:0]           busy;
    logic [NREG-1:0]           reg_we;
    logic [NREG-1:0][XLEN-1:0] reg_wd;

    dbg_state_e state, state_nxt;
    logic       dbg_go;

    // debug access waits for a cycle with no core write
    assign dbg_go = (state == IDLE) && bus.dbg_req && bus.halted && ~|bus.wen;

    rfu_wr_arb #(.XLEN(XLEN), .NREG(NREG), .NWP(NWP)) u_arb (
        .wen      (bus.wen),
        .addr     (bus.rd_addr),
        .data     (bus.rd_data),
        .dbg_en   (dbg_go && bus.dbg_wr),
        .dbg_addr (bus.dbg_addr),
        .dbg_data (bus.dbg_wdata),
        .reg_we   (reg_we),
        .reg_wd   (reg_wd)
    );

    // register array and scoreboard; index 0 stays at its reset value of 0
    always_ff @(posedge clk) begin
        if (rst) begin
            gpr  <= '0;
            busy <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (r != 0) begin
                    if (reg_we[r]) gpr[r] <= reg_wd[r];
                    // issue in the same cycle as writeback keeps the reg busy
                    if (bus.issue_en && bus.issue_rd == AW'(r)) busy[r] <= 1'b1;
                    else if (reg_we[r])                          busy[r] <= 1'b0;
                end
            end
        end
    end

    // read ports
    always_comb begin
        bus.rs_data = '0;
        bus.rs_busy = '0;
        for (int i = 0; i < NRP; i++) begin
            bus.rs_data[i] = gpr[bus.rs_addr[i]];
            bus.rs_busy[i] = busy[bus.rs_addr[i]];
`ifdef RFU_BYPASS_EN
            for (int j = 0; j < NWP; j++) begin
                if (bus.wen[j] && bus.rd_addr[j] == bus.rs_addr[i]) begin
                    bus.rs_data[i] = bus.rd_data[j];
                    bus.rs_busy[i] = 1'b0;
                end
            end
`endif
            if (bus.rs_addr[i] == '0) begin
                bus.rs_data[i] = '0;
                bus.rs_busy[i] = 1'b0;
            end
        end
    end

    // debug FSM
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = IDLE;
        bus.dbg_ack = 1'b0;
        case (state)
            IDLE: if (dbg_go) state_nxt = ACK;
            ACK:  bus.dbg_ack = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    // read data captured on the accepting edge, before any write lands
    always_ff @(posedge clk) begin
        if (rst)                        bus.dbg_rdata <= '0;
        else if (dbg_go && !bus.dbg_wr) bus.dbg_rdata <= gpr[bus.dbg_addr];
    end

endmodule

// File: tb/tb_rfu_mp.sv
module tb_rfu_mp;
    import rfu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rfu_mp_if #(.XLEN(32), .NREG(32), .NRP(2), .NWP(2)) bus ();

    rfu_mp #(.XLEN(32), .NREG(32), .NRP(2), .NWP(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic expect_val(input logic [31:0] e);
        exp_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (obs === e) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    task automatic drive_wr(input rfu_wr_t w0, input rfu_wr_t w1);
        bus.wen[0] = w0.en; bus.rd_addr[0] = w0.addr; bus.rd_data[0] = w0.data;
        bus.wen[1] = w1.en; bus.rd_addr[1] = w1.addr; bus.rd_data[1] = w1.data;
    endtask

    rfu_wr_t nowr;

    initial begin
        nowr = '0;
        bus.rs_addr = '0; bus.issue_en = 1'b0; bus.issue_rd = '0;
        bus.halted = 1'b0; bus.dbg_req = 1'b0; bus.dbg_wr = 1'b0;
        bus.dbg_addr = '0; bus.dbg_wdata = '0;
        drive_wr(nowr, nowr);

        // reset state
        tick(); tick();
        rst = 1'b0;
        bus.rs_addr[0] = 5;
        mid();
        expect_val(32'h0); chk("reset_rs5", bus.rs_data[0]);
        expect_val(32'h0); chk("reset_busy5", {31'b0, bus.rs_busy[0]});
        expect_val(32'h0); chk("reset_ack", {31'b0, bus.dbg_ack});
        expect_val(32'h0); chk("reset_rdata", bus.dbg_rdata);

        // write addr 5; same-cycle read shows bypass or old value
        tick();
        drive_wr('{en:1'b1, addr:5'd5, data:32'hDEADBEEF}, nowr);
        mid();
`ifdef RFU_BYPASS_EN
        expect_val(32'hDEADBEEF);
`else
        expect_val(32'h0);
`endif
        chk("samecyc_rs5", bus.rs_data[0]);
        tick();
        drive_wr(nowr, nowr);
        mid();
        expect_val(32'hDEADBEEF); chk("wr_rs5", bus.rs_data[0]);

        // collision on addr 7: port 1 wins; write to addr 0 is dropped
        tick();
        drive_wr('{en:1'b1, addr:5'd7, data:32'h11}, '{en:1'b1, addr:5'd7, data:32'h22});
        tick();
        drive_wr('{en:1'b1, addr:5'd0, data:32'hFFFF}, nowr);
        bus.rs_addr[1] = 7;
        mid();
        expect_val(32'h22); chk("collide_rs7", bus.rs_data[1]);
        tick();
        drive_wr(nowr, nowr);
        bus.rs_addr[0] = 0;
        mid();
        expect_val(32'h0); chk("zero_rs0", bus.rs_data[0]);

        // scoreboard: issue sets, write clears, issue+write keeps set
        tick();
        bus.issue_en = 1'b1; bus.issue_rd = 3;
        bus.rs_addr[0] = 3;
        tick();
        bus.issue_en = 1'b0;
        mid();
        expect_val(32'h1); chk("issue_busy3", {31'b0, bus.rs_busy[0]});
        tick();
        drive_wr('{en:1'b1, addr:5'd3, data:32'h33}, nowr);
        mid();
`ifdef RFU_BYPASS_EN
        expect_val(32'h0);
`else
        expect_val(32'h1);
`endif
        chk("wb_samecyc_busy3", {31'b0, bus.rs_busy[0]});
        tick();
        drive_wr(nowr, nowr);
        mid();
        expect_val(32'h0);  chk("wb_busy3", {31'b0, bus.rs_busy[0]});
        expect_val(32'h33); chk("wb_rs3", bus.rs_data[0]);
        tick();
        bus.issue_en = 1'b1; bus.issue_rd = 3;
        drive_wr('{en:1'b1, addr:5'd3, data:32'h44}, nowr);
        tick();
        bus.issue_en = 1'b1; bus.issue_rd = 9;   // also mark 9 busy for later
        drive_wr(nowr, nowr);
        mid();
        expect_val(32'h1);  chk("setwins_busy3", {31'b0, bus.rs_busy[0]});
        expect_val(32'h44); chk("setwins_rs3", bus.rs_data[0]);
        tick();
        bus.issue_en = 1'b1; bus.issue_rd = 0;
        bus.rs_addr[1] = 9;
        tick();
        bus.issue_en = 1'b0;
        bus.rs_addr[0] = 0;
        mid();
        expect_val(32'h0); chk("issue0_busy0", {31'b0, bus.rs_busy[0]});
        expect_val(32'h1); chk("issue_busy9", {31'b0, bus.rs_busy[1]});

        // debug read blocked while running
        tick();
        bus.dbg_req = 1'b1; bus.dbg_wr = 1'b0; bus.dbg_addr = 5;
        for (int k = 0; k < 10; k++) begin
            mid();
            expect_val(32'h0); chk("run_noack", {31'b0, bus.dbg_ack});
            tick();
        end
        bus.halted = 1'b1;
        mid();
        expect_val(32'h0); chk("halt_preack", {31'b0, bus.dbg_ack});
        tick();
        mid();
        expect_val(32'h1);         chk("dbgrd_ack", {31'b0, bus.dbg_ack});
        expect_val(32'hDEADBEEF);  chk("dbgrd_data", bus.dbg_rdata);
        tick();
        bus.dbg_req = 1'b0;
        mid();
        expect_val(32'h0); chk("dbgrd_ackpulse", {31'b0, bus.dbg_ack});

        // debug write held off by core writes
        tick();
        bus.dbg_req = 1'b1; bus.dbg_wr = 1'b1; bus.dbg_addr = 9;
        bus.dbg_wdata = 32'hA5A5A5A5;
        drive_wr('{en:1'b1, addr:5'd2, data:32'h2}, nowr);
        for (int k = 0; k < 3; k++) begin
            mid();
            expect_val(32'h0); chk("wrblk_noack", {31'b0, bus.dbg_ack});
            tick();
        end
        drive_wr(nowr, nowr);
        mid();
        expect_val(32'h0); chk("wrblk_noack_last", {31'b0, bus.dbg_ack});
        tick();
        bus.rs_addr[0] = 9; bus.rs_addr[1] = 2;
        mid();
        expect_val(32'h1);        chk("dbgwr_ack", {31'b0, bus.dbg_ack});
        expect_val(32'hA5A5A5A5); chk("dbgwr_rs9", bus.rs_data[0]);
        expect_val(32'h0);        chk("dbgwr_busy9", {31'b0, bus.rs_busy[0]});
        expect_val(32'h2);        chk("core_rs2", bus.rs_data[1]);
        tick();
        bus.dbg_req = 1'b0;
        mid();
        expect_val(32'h0);        chk("dbgwr_ackpulse", {31'b0, bus.dbg_ack});
        expect_val(32'hDEADBEEF); chk("rdata_held", bus.dbg_rdata);

        // reset coincident with an accepted debug write: discarded, no ack
        tick();
        bus.dbg_req = 1'b1; bus.dbg_wr = 1'b1; bus.dbg_addr = 10;
        bus.dbg_wdata = 32'h77;
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.dbg_req = 1'b0;
        bus.rs_addr[0] = 10;
        mid();
        expect_val(32'h0); chk("rstmid_ack", {31'b0, bus.dbg_ack});
        expect_val(32'h0); chk("rstmid_rs10", bus.rs_data[0]);
        expect_val(32'h0); chk("rstmid_rs9", {31'b0, bus.rs_busy[1]} | bus.rs_data[1]);
        tick();
        mid();
        expect_val(32'h0); chk("rstmid_noack_late", {31'b0, bus.dbg_ack});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
